// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - generic valid/ready pipeline stage register with a 2-entry skid buffer.
// Optional stall/bubble statistics counters are enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_skid #(
  parameter int DATA_W      = 160,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_we,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_we,
  output logic [1:0]        occupancy,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
);

  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              main_we;
  logic              skid_we;
  logic              accept;
  logic              drain;

  // in_ready comes straight from a flop, so out_ready never reaches it combinationally
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      main_we    <= 1'b0;
      skid_we    <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_we    <= skid_we;
        skid_valid <= 1'b0;
        skid_data  <= '0;
        skid_we    <= 1'b0;
      end else if (accept) begin
        main_data <= in_data;
        main_we   <= in_we;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (main_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
        skid_we    <= in_we;
      end else begin
        main_valid <= 1'b1;
        main_data  <= in_data;
        main_we    <= in_we;
      end
    end
  end

  assign out_valid = main_valid;
  assign out_we    = main_valid && main_we;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  generate
    if (ZERO_BUBBLE) begin : g_zero_bubble
      assign out_data = main_valid ? main_data : '0;
    end else begin : g_hold_bubble
      assign out_data = main_data;
    end
  endgenerate

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] bubble_q;

  // both counters saturate rather than wrap; only reset clears them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (main_valid && !out_ready && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
      if (!main_valid && !flush && (bubble_q != 32'hFFFF_FFFF))
        bubble_q <= bubble_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor of the fixed per-stage pipeline registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- One generic stage register carries a DATA_W-bit payload plus a write-enable sideband.
- Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure is registered and never combinational from out_ready to in_ready.
- Flush inserts a zero bubble, which is a NOP with write-enable low.

Parameters:
DATA_W, 160, payload width (IR + PC8 + RData1 + RData2 + EXT = 5 x 32).
ZERO_BUBBLE, 1, 1: out_data is forced to all-zero whenever out_valid=0; 0: out_data holds its last value when out_valid=0.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk externally).
in_valid  input  1  upstream beat present.
in_ready  output  1  stage can accept a beat this cycle; registered.
in_data  input  DATA_W  upstream payload.
in_we  input  1  upstream register-file write enable.
flush  input  1  discard all held beats and the beat offered this cycle.
out_valid  output  1  beat presented downstream.
out_ready  input  1  downstream accepts this cycle.
out_data  output  DATA_W  payload to next stage.
out_we  output  1  write enable; 0 whenever out_valid=0.
occupancy  output  2  beats held: 0, 1 or 2.
stall_cnt  output  32  see Optional Feature.
bubble_cnt  output  32  see Optional Feature.

Behaviour:
- Storage: main entry (drives the outputs directly) and skid entry. Each entry has a data field, a we field and a valid bit.
- Reset (reset=0, asynchronous):
  - both valid bits = 0, all data = 0, we = 0.
  - in_ready = 1, occupancy = 0, counters = 0.
- Handshake: a beat transfers in on in_valid & in_ready, and transfers out on out_valid & out_ready.
- in_ready = !skid_valid, a registered flag. It never depends on out_ready in the same cycle.
- States, encoded as occupancy:
  - EMPTY(0):
    - accept -> FULL1, with the beat loaded into main.
  - FULL1(1):
    - accept & drain -> FULL1, with main reloaded.
    - accept & !drain -> FULL2, with the beat loaded into skid.
    - drain & !accept -> EMPTY.
    - otherwise hold.
  - FULL2(2):
    - in_ready = 0, so no accept.
    - drain -> FULL1, with skid moved into main and skid cleared.
    - !drain -> hold; data is stable while stalled.
- Latency: 1 cycle from accept to out_valid when EMPTY. Order is strictly FIFO. No beat is duplicated or lost absent flush.
- Flush, sampled at the clock edge, has priority over everything:
  - both valids cleared, next state EMPTY.
  - the in_valid beat offered that cycle is dropped, even if in_ready=1.
  - a downstream handshake in the flush cycle still completes on the current main beat.
- Bubble: when out_valid=0, out_we=0 always.
  - ZERO_BUBBLE=1: out_data = 0.
  - ZERO_BUBBLE=0: out_data is unspecified-but-stable; it holds its last value.
- Reset mid-operation discards all held beats with no partial update. The first cycle after deassertion behaves as EMPTY.
- No combinational path exists from in_* to out_* or from out_ready to in_ready.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - bubble_cnt increments each cycle with !out_valid & !flush.
  - both are 32-bit and saturate at 0xFFFFFFFF.
  - both are cleared by reset only; flush does not clear them.
- Undefined: stall_cnt and bubble_cnt are tied to 0, and no counter flops are synthesised.

Test Plan:
- Reset, then idle: reset=0 for 3 cycles, release -> out_valid=0, out_we=0, out_data=0, in_ready=1, occupancy=0.
- Streaming: in_valid=1 with payloads 1..8 and in_we=1, out_ready=1 throughout -> out_data = 1..8 on consecutive cycles, 1-cycle latency, in_ready=1 throughout, occupancy=1.
- Backpressure: send A, B, C; hold out_ready=0 from the cycle A appears -> B enters skid, occupancy=2, in_ready=0, C is held upstream; raise out_ready -> A, B, C are delivered in order with no drop.
- Flush in FULL2 while in_valid=1 with payload D -> next cycle occupancy=0, out_valid=0, out_data=0, and D never appears at the output.
- Async reset mid-stream: assert reset between clock edges while occupancy=2 -> outputs clear immediately without waiting for clk, and the post-release first accepted beat is delivered correctly.
- With PIPE_STAGE_STATS_EN: 5 stall cycles and 3 idle cycles -> stall_cnt=5, bubble_cnt=3; preloading near saturation shows the counters holding at 0xFFFFFFFF. Without the macro, both counters read 0.
